// File: rtl/pll_seq_pkg.sv
// rtl/pll_seq_pkg.sv - shared state encoding and counter sizing for the PLL lock sequencer
package pll_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HOLD,
    WAIT_LOCK,
    STABLE,
    RUN,
    FAIL
  } state_t;

  // Wide enough to name any PLL of the largest supported cascade (8).
  localparam int IDX_W = 3;

  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// rtl/pll_lock_sync.sv - two-flop synchronizer for the raw PLL LOCKED inputs
module pll_lock_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_lock_sequencer.sv
// rtl/pll_lock_sequencer.sv - ordered bring-up and lock supervision of a cascaded PLL chain
// Optional macro LOCK_LOSS_RECOVER_EN: re-sequence from the lost PLL instead of failing in RUN.
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int NUM_PLL          = 3,
  parameter int RST_HOLD_CYC     = 16,
  parameter int LOCK_STABLE_CYC  = 256,
  parameter int LOCK_TIMEOUT_CYC = 65536,
  parameter int MAX_RETRY        = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [NUM_PLL-1:0] pll_locked,
  output logic [NUM_PLL-1:0] pll_rstn,
  output logic [NUM_PLL-1:0] domain_rstn,
  output logic               all_locked,
  output logic               fail,
  output logic [2:0]         fail_idx,
  output logic [3:0]         retry_cnt
);

  localparam int CYC_W = cnt_w(max2(RST_HOLD_CYC, LOCK_TIMEOUT_CYC));
  localparam int STB_W = cnt_w(LOCK_STABLE_CYC);

  localparam logic [CYC_W-1:0] HOLD_LAST = CYC_W'(RST_HOLD_CYC - 1);
  localparam logic [CYC_W-1:0] TO_LAST   = CYC_W'(LOCK_TIMEOUT_CYC - 1);
  localparam logic [CYC_W-1:0] CYC_SAT   = '1;
  localparam logic [STB_W-1:0] STB_DONE  = STB_W'(LOCK_STABLE_CYC);
  localparam logic [STB_W-1:0] STB_ONE   = STB_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_PLL - 1);
  localparam logic [3:0]       RETRY_MAX = 4'(MAX_RETRY);

  state_t state, state_n;

  logic [IDX_W-1:0]   idx, idx_n;
  logic [CYC_W-1:0]   cyc, cyc_n, cyc_inc;
  logic [STB_W-1:0]   stab, stab_n, stab_inc;
  logic [3:0]         retry_n;
  logic [NUM_PLL-1:0] pll_n, dom_n;
  logic               all_n, fail_n;

  logic [NUM_PLL-1:0] lock_sync, sel;
  logic [NUM_PLL-1:0] loss_ge, loss_low, loss_gt;
  logic [IDX_W-1:0]   loss_idx;
  logic               seen, lock_cur, timeout;

  pll_lock_sync #(.WIDTH(NUM_PLL)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pll_locked),
    .q     (lock_sync)
  );

  assign sel      = NUM_PLL'(1) << idx;
  assign lock_cur = |(lock_sync & sel);
  assign cyc_inc  = (cyc == CYC_SAT) ? cyc : cyc + CYC_W'(1);
  assign stab_inc = (stab == STB_DONE) ? stab : stab + STB_W'(1);
  assign fail_idx = idx;

  // Lowest unlocked PLL and the masks of it-and-downstream / strictly-downstream.
  always_comb begin
    seen     = 1'b0;
    loss_idx = '0;
    loss_ge  = '0;
    for (int i = 0; i < NUM_PLL; i++) begin
      if (!lock_sync[i] && !seen) begin
        seen     = 1'b1;
        loss_idx = IDX_W'(i);
      end
      loss_ge[i] = seen;
    end
  end

  assign loss_low = loss_ge & ~(loss_ge << 1);
  assign loss_gt  = loss_ge & ~loss_low;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      idx         <= '0;
      cyc         <= '0;
      stab        <= '0;
      retry_cnt   <= '0;
      pll_rstn    <= '0;
      domain_rstn <= '0;
      all_locked  <= 1'b0;
      fail        <= 1'b0;
    end else begin
      state       <= state_n;
      idx         <= idx_n;
      cyc         <= cyc_n;
      stab        <= stab_n;
      retry_cnt   <= retry_n;
      pll_rstn    <= pll_n;
      domain_rstn <= dom_n;
      all_locked  <= all_n;
      fail        <= fail_n;
    end
  end

  always_comb begin
    state_n = state;
    idx_n   = idx;
    cyc_n   = cyc;
    stab_n  = stab;
    retry_n = retry_cnt;
    pll_n   = pll_rstn;
    dom_n   = domain_rstn;
    all_n   = all_locked;
    fail_n  = fail;
    timeout = 1'b0;

    unique case (state)
      IDLE: begin
        pll_n = '0;
        dom_n = '0;
        if (start) begin
          state_n = HOLD;
          idx_n   = '0;
          retry_n = '0;
          cyc_n   = '0;
        end
      end
      HOLD: begin
        pll_n = pll_rstn & ~sel;
        if (cyc == HOLD_LAST) begin
          pll_n   = pll_rstn | sel;
          cyc_n   = '0;
          state_n = WAIT_LOCK;
        end else begin
          cyc_n = cyc_inc;
        end
      end
      WAIT_LOCK: begin
        if (lock_cur) begin
          state_n = STABLE;
          stab_n  = STB_ONE;
          cyc_n   = cyc_inc;
        end else if (cyc == TO_LAST) begin
          timeout = 1'b1;
        end else begin
          cyc_n = cyc_inc;
        end
      end
      STABLE: begin
        if (stab == STB_DONE) begin
          dom_n   = domain_rstn | sel;
          retry_n = '0;
          cyc_n   = '0;
          if (idx == IDX_LAST) begin
            state_n = RUN;
            all_n   = 1'b1;
          end else begin
            idx_n   = idx + IDX_W'(1);
            state_n = HOLD;
          end
        end else if (cyc == TO_LAST) begin
          timeout = 1'b1;
        end else begin
          cyc_n  = cyc_inc;
          stab_n = lock_cur ? stab_inc : '0;
        end
      end
      RUN: begin
        if (|loss_ge) begin
          all_n = 1'b0;
          dom_n = domain_rstn & ~loss_ge;
          pll_n = pll_rstn & ~loss_gt;
          idx_n = loss_idx;
`ifdef LOCK_LOSS_RECOVER_EN
          pll_n   = pll_n & ~loss_low;
          state_n = HOLD;
          retry_n = '0;
          cyc_n   = '0;
`else
          pll_n   = '0;
          dom_n   = '0;
          fail_n  = 1'b1;
          state_n = FAIL;
`endif
        end
      end
      FAIL: begin
        pll_n = '0;
        dom_n = '0;
        all_n = 1'b0;
      end
      default: state_n = IDLE;
    endcase

    // A retry re-pulses the current PLL's reset; the HOLD count starts fresh.
    if (timeout) begin
      if (retry_cnt < RETRY_MAX) begin
        retry_n = retry_cnt + 4'd1;
        state_n = HOLD;
        cyc_n   = '0;
        pll_n   = pll_rstn & ~sel;
      end else begin
        state_n = FAIL;
        fail_n  = 1'b1;
        pll_n   = '0;
        dom_n   = '0;
      end
    end
  end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// tb/tb_pll_lock_sequencer.sv - randomized self-checking bench with a behavioural PLL and timing model
module tb_pll_lock_sequencer;

  localparam int N    = 3;
  localparam int HOLD = 16;
  localparam int STB  = 8;
  localparam int TO   = 64;
  localparam int MR   = 2;
  localparam int SYNC = 2;

  logic         clk = 1'b0;
  logic         rst_n, start;
  logic [N-1:0] pll_locked, pll_rstn, domain_rstn;
  logic         all_locked, fail;
  logic [2:0]   fail_idx;
  logic [3:0]   retry_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pll_lock_sequencer #(
    .NUM_PLL(N), .RST_HOLD_CYC(HOLD), .LOCK_STABLE_CYC(STB),
    .LOCK_TIMEOUT_CYC(TO), .MAX_RETRY(MR)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pll_locked(pll_locked),
    .pll_rstn(pll_rstn), .domain_rstn(domain_rstn), .all_locked(all_locked),
    .fail(fail), .fail_idx(fail_idx), .retry_cnt(retry_cnt)
  );

  // PLL behaviour and event log, indexed by negedge number n since reset release.
  int n;
  int rel[N], dly[N], gl_c[N], gl_n[N];
  bit en[N], frc[N];
  int pr_rise[N][$], pr_fall[N][$], dm_rise[N][$], dm_fall[N][$];
  int al_rise[$], fl_t[$], rc_t[$], rc_v[$];
  int inv_err, max_rc;
  logic [N-1:0] p_pll, p_dom;
  logic p_al, p_fail;
  logic [3:0] p_rc;

  function automatic int first_of(input int q[$]);
    return (q.size() > 0) ? q[0] : -1;
  endfunction

  function automatic int last_of(input int q[$]);
    return (q.size() > 0) ? q[q.size()-1] : -1;
  endfunction

  task automatic clear_track();
    n = 0;
    for (int i = 0; i < N; i++) begin
      rel[i] = 0; gl_n[i] = -1;
      pr_rise[i].delete(); pr_fall[i].delete(); dm_rise[i].delete(); dm_fall[i].delete();
    end
    al_rise.delete(); fl_t.delete(); rc_t.delete(); rc_v.delete();
    inv_err = 0; max_rc = 0;
    p_pll = pll_rstn; p_dom = domain_rstn; p_al = all_locked; p_fail = fail; p_rc = retry_cnt;
  endtask

  task automatic step();
    @(negedge clk);
    n++;
    for (int i = 0; i < N; i++) begin
      if (pll_rstn[i] && !p_pll[i]) pr_rise[i].push_back(n);
      if (!pll_rstn[i] && p_pll[i]) pr_fall[i].push_back(n);
      if (domain_rstn[i] && !p_dom[i]) dm_rise[i].push_back(n);
      if (!domain_rstn[i] && p_dom[i]) dm_fall[i].push_back(n);
      if (domain_rstn[i] && !pll_rstn[i]) inv_err++;
      if (i > 0 && domain_rstn[i] && !p_dom[i] && !domain_rstn[i-1]) inv_err++;
      rel[i] = pll_rstn[i] ? rel[i] + 1 : 0;
      if (rel[i] == 1) gl_n[i] = (gl_c[i] > 0) ? n + dly[i] - 1 + gl_c[i] : -1;
      pll_locked[i] = en[i] && (rel[i] >= dly[i]) && !frc[i] && (n != gl_n[i]);
    end
    if (all_locked && !p_al) al_rise.push_back(n);
    if (fail && !p_fail) fl_t.push_back(n);
    if (retry_cnt != p_rc) begin rc_t.push_back(n); rc_v.push_back(int'(retry_cnt)); end
    if (int'(retry_cnt) > max_rc) max_rc = int'(retry_cnt);
    p_pll = pll_rstn; p_dom = domain_rstn; p_al = all_locked; p_fail = fail; p_rc = retry_cnt;
  endtask

  task automatic run(input int cnt);
    repeat (cnt) step();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; start = 1'b0; pll_locked = '0;
    for (int i = 0; i < N; i++) begin
      en[i] = 1'b1; frc[i] = 1'b0; gl_c[i] = 0; dly[i] = 10;
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clear_track();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({pll_rstn, domain_rstn, all_locked, fail, fail_idx, retry_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_values: got pll=%b dom=%b al=%b fail=%b idx=%0d rc=%0d want all 0",
               pll_rstn, domain_rstn, all_locked, fail, fail_idx, retry_cnt);
    end
    run(20);
    checks++;
    if (pr_rise[0].size() != 0 || pll_rstn !== '0) begin
      errors++;
      $display("FAIL idle_no_start: got %0d releases pll=%b want 0 releases pll=000", pr_rise[0].size(), pll_rstn);
    end
  endtask

  // Expected chain: release r, lock rise at r+dly-1 (+glitch), domain after sync+stable+1, next release HOLD later.
  task automatic test_sequence(input string name, input int glitch_pll, input int glitch_c);
    int r, er[N], ed[N];
    do_reset();
    for (int i = 0; i < N; i++) dly[i] = $urandom_range(1, 20);
    if (glitch_pll >= 0) gl_c[glitch_pll] = glitch_c;
    start = 1'b1; step(); start = 1'b0;
    run(250);
    r = 1 + HOLD;
    for (int i = 0; i < N; i++) begin
      er[i] = r;
      ed[i] = r + dly[i] - 1 + ((i == glitch_pll) ? glitch_c + 1 : 0) + SYNC + STB + 1;
      r = ed[i] + HOLD;
    end
    for (int i = 0; i < N; i++) begin
      checks++;
      if (pr_rise[i].size() != 1 || first_of(pr_rise[i]) != er[i]) begin
        errors++;
        $display("FAIL %s pll_rstn[%0d]_release: got n=%0d (x%0d) want n=%0d", name, i, first_of(pr_rise[i]), pr_rise[i].size(), er[i]);
      end
      checks++;
      if (dm_rise[i].size() != 1 || first_of(dm_rise[i]) != ed[i]) begin
        errors++;
        $display("FAIL %s domain_rstn[%0d]_release: got n=%0d (x%0d) want n=%0d", name, i, first_of(dm_rise[i]), dm_rise[i].size(), ed[i]);
      end
    end
    checks++;
    if (all_locked !== 1'b1 || first_of(al_rise) != ed[N-1]) begin
      errors++;
      $display("FAIL %s all_locked: got %b at n=%0d want 1 at n=%0d", name, all_locked, first_of(al_rise), ed[N-1]);
    end
    checks++;
    if (max_rc != 0 || inv_err != 0 || fail !== 1'b0) begin
      errors++;
      $display("FAIL %s retry_invariants: got max_retry=%0d inv_err=%0d fail=%b want 0 0 0", name, max_rc, inv_err, fail);
    end
  endtask

  task automatic test_nominal();
    for (int it = 0; it < 3; it++) test_sequence("nominal", -1, 0);
  endtask

  task automatic test_glitch();
    test_sequence("glitch_c5", 1, 5);
    test_sequence("glitch_rand", int'($urandom_range(0, N-1)), int'($urandom_range(1, STB-1)));
  endtask

  task automatic test_timeout();
    int r, r2;
    do_reset();
    dly[0] = $urandom_range(1, 20); dly[1] = $urandom_range(1, 20); en[2] = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    run(400);
    r = 1 + HOLD;
    for (int i = 0; i < 2; i++) r = r + dly[i] - 1 + SYNC + STB + 1 + HOLD;
    r2 = r;
    checks++;
    if (pr_rise[2].size() != MR + 1 || pr_fall[2].size() != MR + 1) begin
      errors++;
      $display("FAIL timeout_pulse_count: got %0d releases %0d asserts want %0d each", pr_rise[2].size(), pr_fall[2].size(), MR + 1);
    end
    for (int j = 0; j <= MR; j++) begin
      checks++;
      if (j < pr_rise[2].size() && j < pr_fall[2].size() &&
          (pr_rise[2][j] != r2 + j * (TO + HOLD) || pr_fall[2][j] != r2 + j * (TO + HOLD) + TO)) begin
        errors++;
        $display("FAIL timeout_pulse_%0d: got rise=%0d fall=%0d want rise=%0d fall=%0d", j,
                 pr_rise[2][j], pr_fall[2][j], r2 + j * (TO + HOLD), r2 + j * (TO + HOLD) + TO);
      end
    end
    for (int j = 0; j < MR; j++) begin
      checks++;
      if (rc_t.size() != MR || rc_t[j] != r2 + j * (TO + HOLD) + TO || rc_v[j] != j + 1) begin
        errors++;
        $display("FAIL timeout_retry_cnt_%0d: got %0d changes, n=%0d val=%0d want n=%0d val=%0d", j, rc_t.size(),
                 first_of(rc_t), first_of(rc_v), r2 + j * (TO + HOLD) + TO, j + 1);
      end
    end
    checks++;
    if (first_of(fl_t) != r2 + MR * (TO + HOLD) + TO || fail !== 1'b1 || fail_idx !== 3'd2) begin
      errors++;
      $display("FAIL timeout_fail: got fail=%b at n=%0d idx=%0d want 1 at n=%0d idx=2", fail, first_of(fl_t), fail_idx,
               r2 + MR * (TO + HOLD) + TO);
    end
    start = 1'b1; run(20); start = 1'b0;
    checks++;
    if ({pll_rstn, domain_rstn, all_locked} !== '0 || fail !== 1'b1 || pr_rise[2].size() != MR + 1) begin
      errors++;
      $display("FAIL fail_sticky: got pll=%b dom=%b al=%b fail=%b want 000 000 0 1", pll_rstn, domain_rstn, all_locked, fail);
    end
  endtask

  task automatic test_run_loss();
    int k, f, r, ed;
    logic [N-1:0] below, above;
    do_reset();
    for (int i = 0; i < N; i++) dly[i] = $urandom_range(1, 20);
    start = 1'b1; step(); start = 1'b0;
    run(250);
    checks++;
    if (all_locked !== 1'b1) begin
      errors++; $display("FAIL run_reached: got all_locked=%b want 1", all_locked);
    end
    k = $urandom_range(0, N-1);
    below = '0; above = '0;
    for (int i = 0; i < N; i++) begin
      below[i] = (i < k);
      above[i] = (i > k);
    end
    frc[k] = 1'b1; step(); f = n;
    run(SYNC);
    checks++;
    if (all_locked !== 1'b1 || domain_rstn !== '1) begin
      errors++; $display("FAIL loss_latency_early: got al=%b dom=%b want 1 111", all_locked, domain_rstn);
    end
    step();
    frc[k] = 1'b0;
`ifdef LOCK_LOSS_RECOVER_EN
    checks++;
    if (all_locked !== 1'b0 || domain_rstn !== below || (pll_rstn & (below | above)) !== below) begin
      errors++;
      $display("FAIL loss_k%0d_drop: got al=%b dom=%b pll=%b want 0 dom=%b pll(excl k)=%b", k, all_locked, domain_rstn, pll_rstn, below, below);
    end
    run(250);
    r = f + SYNC + 1 + HOLD;
    ed = 0;
    for (int i = k; i < N; i++) begin
      ed = r + dly[i] - 1 + SYNC + STB + 1;
      checks++;
      if (last_of(pr_rise[i]) != r || last_of(dm_rise[i]) != ed) begin
        errors++;
        $display("FAIL relock_%0d: got rel=%0d dom=%0d want rel=%0d dom=%0d", i, last_of(pr_rise[i]), last_of(dm_rise[i]), r, ed);
      end
      r = ed + HOLD;
    end
    checks++;
    if (all_locked !== 1'b1 || al_rise.size() != 2 || last_of(al_rise) != ed || inv_err != 0) begin
      errors++;
      $display("FAIL relock_all: got al=%b x%0d at n=%0d inv=%0d want 1 x2 at n=%0d inv=0", all_locked, al_rise.size(), last_of(al_rise), inv_err, ed);
    end
    for (int i = 0; i < k; i++) begin
      checks++;
      if (dm_fall[i].size() != 0 || pr_fall[i].size() != 0) begin
        errors++; $display("FAIL upstream_%0d_kept: got %0d domain drops want 0", i, dm_fall[i].size());
      end
    end
`else
    checks++;
    if (fail !== 1'b1 || fail_idx !== 3'(k) || {pll_rstn, domain_rstn, all_locked} !== '0) begin
      errors++;
      $display("FAIL loss_k%0d_fail: got fail=%b idx=%0d pll=%b dom=%b al=%b want 1 %0d 000 000 0", k, fail, fail_idx,
               pll_rstn, domain_rstn, all_locked, k);
    end
    start = 1'b1; run(30); start = 1'b0;
    checks++;
    if (fail !== 1'b1 || pll_rstn !== '0 || fail_idx !== 3'(k)) begin
      errors++; $display("FAIL loss_fail_sticky: got fail=%b pll=%b idx=%0d want 1 000 %0d", fail, pll_rstn, fail_idx, k);
    end
`endif
  endtask

  task automatic test_async_reset();
    do_reset();
    en[0] = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    while (n < 1 + HOLD + TO + HOLD + 3) step();
    checks++;
    if (pll_rstn[0] !== 1'b1 || retry_cnt !== 4'd1) begin
      errors++; $display("FAIL async_precond: got pll0=%b rc=%0d want 1 1", pll_rstn[0], retry_cnt);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({pll_rstn, domain_rstn, all_locked, fail, fail_idx, retry_cnt} !== '0) begin
      errors++;
      $display("FAIL async_reset: got pll=%b dom=%b al=%b fail=%b rc=%0d want all 0", pll_rstn, domain_rstn, all_locked, fail, retry_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    en[0] = 1'b1;
    clear_track();
    run(60);
    checks++;
    if (pr_rise[0].size() != 0 || {pll_rstn, domain_rstn, all_locked, fail, retry_cnt} !== '0) begin
      errors++; $display("FAIL post_reset_idle: got %0d releases pll=%b want 0 000", pr_rise[0].size(), pll_rstn);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; pll_locked = '0;
    test_reset();
    test_nominal();
    test_glitch();
    test_timeout();
    test_run_loss();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion want completion before 50000 cycles");
    $fatal(1, "watchdog expired");
  end

endmodule
